// File: rtl/lfsr_challenge_gen_pkg.sv
// Shared types and constants for the LFSR challenge generator.
package lfsr_challenge_pkg;

  localparam int unsigned LFSR_WIDTH   = 16;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam int unsigned WORDS_PER_CH = 4;
  localparam int unsigned IDX_W        = $clog2(WORDS_PER_CH);
  localparam logic [15:0] SAFE_SEED    = 16'h0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_challenge_gen_if.sv
// Challenge handshake bus between the generator (master) and the MAC (slave).
//   ch_valid : challenge available
//   ch_ready : consumer accepts the challenge
//   ch_data  : {word0, word1, word2, word3}, word0 in the top bits
interface lfsr_challenge_gen_if #(
  parameter int unsigned WIDTH = 16
);

  logic                 ch_valid;
  logic                 ch_ready;
  logic [4*WIDTH-1:0]   ch_data;

  modport master (output ch_valid, output ch_data, input ch_ready);
  modport slave  (input ch_valid, input ch_data, output ch_ready);

endinterface

// File: rtl/lfsr_challenge_gen_step.sv
// Combinational Galois LFSR advance: next = (cur >> 1) ^ (cur[0] ? TAPS : 0).
//   cur    : current LFSR value
//   next_c : value after one step
module lfsr_step #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] next_c
);

  assign next_c = (cur >> 1) ^ (cur[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_challenge_gen.sv
// LFSR challenge generator: emits challenges of four LFSR words over a
// valid/ready handshake, seeded from the uP register bus.
// Optional feature macro: LFSR_CHALLENGE_STEP_CNT_EN (adds step_cnt output).
// Ports:
//   up_clk, up_rst     : clock, synchronous active-high reset
//   seed_wr, seed_data : seed register write strobe and value
//   start, stop, count : run control (count = 0 means free-run)
//   ch                 : challenge handshake bus (master side)
//   busy, done         : run in progress, one-cycle end-of-run pulse
//   step_cnt           : LFSR advances since last accepted start (optional)
module lfsr_challenge_gen
  import lfsr_challenge_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter int unsigned      CNT_W = 16
) (
  input  logic                 up_clk,
  input  logic                 up_rst,
  input  logic                 seed_wr,
  input  logic [WIDTH-1:0]     seed_data,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_W-1:0]     count,
  lfsr_challenge_gen_if.master ch,
  output logic                 busy,
  output logic                 done
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
  ,
  output logic [31:0]          step_cnt
`endif
);

  state_e                               state_q, state_d;
  logic [WIDTH-1:0]                     seed_q, seed_d;
  logic [WIDTH-1:0]                     lfsr_q, lfsr_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [CNT_W-1:0]                     rem_q, rem_d;
  logic [WORDS_PER_CH-1:0][WIDTH-1:0]   words_q, words_d;
  logic                                 valid_q, valid_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;
  logic [WIDTH-1:0]                     lfsr_next_c;
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
  logic [31:0]                          step_q, step_d;
`endif

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .cur    (lfsr_q),
    .next_c (lfsr_next_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    words_d = words_q;
    done_d  = 1'b0;
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
    step_d  = step_q;
`endif

    // All-zero is the LFSR lockup state, so it is replaced by a safe seed.
    if (seed_wr) begin
      seed_d = (seed_data == '0) ? WIDTH'(SAFE_SEED) : seed_data;
    end

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = GEN;
          lfsr_d  = seed_q;
          rem_d   = count;
          idx_d   = '0;
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
          step_d  = '0;
`endif
        end
      end
      GEN: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          // word0 lives in the top slice of the packed word array.
          words_d[IDX_W'(WORDS_PER_CH - 1) - idx_q] = lfsr_next_c;
          lfsr_d = lfsr_next_c;
          idx_d  = idx_q + IDX_W'(1);
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
          if (step_q != '1) step_d = step_q + 32'd1;
`endif
          if (idx_q == IDX_W'(WORDS_PER_CH - 1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (ch.ch_ready) begin
          idx_d = '0;
          // rem_q is only zero here for a free-running run.
          if (rem_q == '0) begin
            state_d = GEN;
          end else begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = GEN;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == HOLD);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state_q <= IDLE;
      seed_q  <= WIDTH'(SAFE_SEED);
      lfsr_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
      step_q  <= step_d;
`endif
    end
  end

  assign ch.ch_valid = valid_q;
  assign ch.ch_data  = words_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
  assign step_cnt    = step_q;
`endif

endmodule

// File: tb/tb_lfsr_challenge_gen.sv
// Self-checking bench for lfsr_challenge_gen: vector table plus hand-written
// corner sequences, with a queue scoreboard of expected challenges.
module tb_lfsr_challenge_gen;

  logic        up_clk = 1'b0;
  logic        up_rst;
  logic        seed_wr;
  logic [15:0] seed_data;
  logic        start;
  logic        stop;
  logic [15:0] count;
  logic        busy;
  logic        done;
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
  logic [31:0] step_cnt;
`endif

  lfsr_challenge_gen_if #(.WIDTH(16)) ch_bus ();

  lfsr_challenge_gen dut (
    .up_clk    (up_clk),
    .up_rst    (up_rst),
    .seed_wr   (seed_wr),
    .seed_data (seed_data),
    .start     (start),
    .stop      (stop),
    .count     (count),
    .ch        (ch_bus.master),
    .busy      (busy),
    .done      (done)
`ifdef LFSR_CHALLENGE_STEP_CNT_EN
    ,
    .step_cnt  (step_cnt)
`endif
  );

  always #5 up_clk = ~up_clk;

  typedef struct {
    logic        wr;
    logic [15:0] seed;
    logic [15:0] cnt;
    int          stall;
    logic [63:0] exp_first;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb[$];
  logic [15:0] m_seed;
  logic [63:0] last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Push n expected challenges starting from the model seed.
  task automatic push_run(input int n);
    logic [15:0] l;
    logic [63:0] c;
    l = m_seed;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 4; w++) begin
        l = m_step(l);
        c = {c[47:0], l};
      end
      sb.push_back(c);
    end
  endtask

  // Consume n challenges of a started run; ends after the final handshake.
  task automatic consume(input int n, input int stall, input bit last_ends,
                         input logic [63:0] exp_first);
    int          lat;
    logic [63:0] held;
    logic [63:0] exp;
    bit          stable;
    for (int i = 0; i < n; i++) begin
      ch_bus.ch_ready = (stall == 0);
      lat = 1;
      while (!ch_bus.ch_valid && lat < 40) begin
        tick();
        lat++;
      end
      if (!ch_bus.ch_valid) begin
        check("valid_timeout", 64'(ch_bus.ch_valid), 64'd1);
        return;
      end
      check("valid_latency", 64'(lat), 64'd5);
      if (i == 0) check("first_challenge", ch_bus.ch_data, exp_first);
      if (stall > 0) begin
        held = ch_bus.ch_data;
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
          tick();
          if (!ch_bus.ch_valid || ch_bus.ch_data !== held) stable = 1'b0;
        end
        check("stall_stable", 64'(stable), 64'd1);
        ch_bus.ch_ready = 1'b1;
      end
      exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
      check("sb_data", ch_bus.ch_data, exp);
      last_data = ch_bus.ch_data;
      tick();
    end
    ch_bus.ch_ready = 1'b0;
    if (last_ends) begin
      check("done_pulse", 64'(done), 64'd1);
      check("busy_at_done", 64'(busy), 64'd0);
      tick();
      check("done_single", 64'(done), 64'd0);
      check("valid_after_run", 64'(ch_bus.ch_valid), 64'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.wr) begin
      seed_wr = 1'b1;
      seed_data = v.seed;
      tick();
      seed_wr = 1'b0;
      m_seed = (v.seed == 16'h0) ? 16'h0001 : v.seed;
    end
    push_run(int'(v.cnt));
    start = 1'b1;
    count = v.cnt;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    consume(int'(v.cnt), v.stall, 1'b1, v.exp_first);
  endtask

  initial begin
    vec_t vecs[4];
    bit   quiet;

    vecs[0] = '{wr: 1'b0, seed: 16'h0000, cnt: 16'd1, stall: 0, exp_first: 64'hB400_5A00_2D00_1680};
    vecs[1] = '{wr: 1'b1, seed: 16'h0000, cnt: 16'd1, stall: 0, exp_first: 64'hB400_5A00_2D00_1680};
    vecs[2] = '{wr: 1'b1, seed: 16'hACE1, cnt: 16'd3, stall: 1, exp_first: 64'hE270_7138_389C_1C4E};
    vecs[3] = '{wr: 1'b1, seed: 16'h0002, cnt: 16'd2, stall: 0, exp_first: 64'h0001_B400_5A00_2D00};

    up_rst = 1'b1;
    seed_wr = 1'b0;
    seed_data = 16'h0;
    start = 1'b0;
    stop = 1'b0;
    count = 16'd0;
    ch_bus.ch_ready = 1'b0;
    m_seed = 16'h0001;
    tick();
    tick();
    up_rst = 1'b0;
    tick();

    check("rst_valid", 64'(ch_bus.ch_valid), 64'd0);
    check("rst_data", ch_bus.ch_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // count=2 with a 3-cycle stall on each challenge, from seed 1.
    run_vec('{wr: 1'b1, seed: 16'h0001, cnt: 16'd2, stall: 3, exp_first: 64'hB400_5A00_2D00_1680});
    check("second_challenge", last_data, 64'h0B40_05A0_02D0_0168);

    // Free-run: 10 accepted challenges, then stop with ready high in HOLD.
    push_run(11);
    start = 1'b1;
    count = 16'd0;
    tick();
    start = 1'b0;
    consume(10, 0, 1'b0, 64'hB400_5A00_2D00_1680);
    ch_bus.ch_ready = 1'b1;
    for (int k = 0; k < 10 && !ch_bus.ch_valid; k++) tick();
    check("free_11th", ch_bus.ch_data, sb.size() > 0 ? sb.pop_front() : 64'hX);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ch_bus.ch_ready = 1'b0;
    check("stop_valid_drop", 64'(ch_bus.ch_valid), 64'd0);
    check("stop_done", 64'(done), 64'd1);
    check("stop_busy", 64'(busy), 64'd0);
    quiet = 1'b1;
    tick();
    if (done) quiet = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ch_bus.ch_valid || busy) quiet = 1'b0;
    end
    check("stop_stays_idle", 64'(quiet), 64'd1);

    // Reset in the second GEN cycle; seed register also returns to 1.
    seed_wr = 1'b1;
    seed_data = 16'hACE1;
    tick();
    seed_wr = 1'b0;
    start = 1'b1;
    count = 16'd1;
    tick();
    start = 1'b0;
    tick();
    up_rst = 1'b1;
    tick();
    up_rst = 1'b0;
    check("midrst_valid", 64'(ch_bus.ch_valid), 64'd0);
    check("midrst_data", ch_bus.ch_data, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    m_seed = 16'h0001;
    run_vec('{wr: 1'b0, seed: 16'h0000, cnt: 16'd1, stall: 0, exp_first: 64'hB400_5A00_2D00_1680});

    // start and stop together in IDLE: nothing happens.
    start = 1'b1;
    stop = 1'b1;
    count = 16'd1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("startstop_busy", 64'(busy), 64'd0);
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ch_bus.ch_valid || busy || done) quiet = 1'b0;
    end
    check("startstop_idle", 64'(quiet), 64'd1);

    // seed_wr with start: this run uses the old seed, the next one the new seed.
    push_run(1);
    seed_wr = 1'b1;
    seed_data = 16'h0003;
    start = 1'b1;
    count = 16'd1;
    tick();
    seed_wr = 1'b0;
    start = 1'b0;
    consume(1, 0, 1'b1, 64'hB400_5A00_2D00_1680);
    m_seed = 16'h0003;
    run_vec('{wr: 1'b0, seed: 16'h0000, cnt: 16'd1, stall: 0, exp_first: 64'hB401_EE00_7700_3B80});

`ifdef LFSR_CHALLENGE_STEP_CNT_EN
    run_vec('{wr: 1'b1, seed: 16'h0001, cnt: 16'd2, stall: 0, exp_first: 64'hB400_5A00_2D00_1680});
    check("step_cnt_after_2", 64'(step_cnt), 64'd8);
    start = 1'b1;
    count = 16'd1;
    tick();
    start = 1'b0;
    check("step_cnt_cleared", 64'(step_cnt), 64'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("step_stop_done", 64'(done), 64'd1);
    tick();
`endif

    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
